// File: rtl/delay_sum_engine.sv
// Delay-and-sum engine: for each output index t it walks the enabled channels, reads each
// channel's delayed sample through two fixed-latency RAM reads, and writes the signed sum.
module delay_sum_engine #(
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 32,
  parameter int SUM_W    = DATA_W + $clog2(NUM_CH),
  parameter int NUM_OUT  = 768,
  parameter int SAMP_AW  = 13,
  parameter int DELAY_AW = 13,
  parameter int OUT_AW   = 10,
  parameter int RAM_LAT  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_CH-1:0]   chan_mask,
  output logic                busy,
  output logic                done,
  output logic                delay_rd_en,
  output logic [DELAY_AW-1:0] delay_rd_addr,
  input  logic [SAMP_AW-1:0]  delay_rd_data,
  output logic                samp_rd_en,
  output logic [SAMP_AW-1:0]  samp_rd_addr,
  input  logic [DATA_W-1:0]   samp_rd_data,
  output logic                sum_wr_en,
  output logic [OUT_AW-1:0]   sum_wr_addr,
  output logic [SUM_W-1:0]    sum_wr_data
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WAIT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DLY_RD, S_DLY_WAIT, S_SMP_RD, S_SMP_WAIT, S_ACC, S_WRITE, S_DONE
  } state_t;

  state_t                    state, next_state;
  logic [NUM_CH-1:0]         mask_q;
  logic [NUM_CH-1:0]         first_mask;
  logic [CH_W-1:0]           ch, next_ch;
  logic [CH_W:0]             first_sel, after_sel;
  logic [OUT_AW-1:0]         t;
  logic [WAIT_W-1:0]         wait_cnt;
  logic                      wait_last, last_t;
  logic signed [DATA_W-1:0]  smp_q;
  logic signed [SUM_W-1:0]   acc;
  logic [DELAY_AW-1:0]       dly_addr_cur, dly_addr_hold;
  logic [SAMP_AW-1:0]        samp_addr_q;
  logic [OUT_AW-1:0]         wr_addr_hold;
  logic [SUM_W-1:0]          wr_data_hold;

  // {found, index} of the lowest set bit of m at or above position lo.
  function automatic logic [CH_W:0] find_from(input logic [NUM_CH-1:0] m, input int lo);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && i >= lo) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  assign wait_last    = (wait_cnt == WAIT_W'(RAM_LAT - 1));
  assign last_t       = (t == OUT_AW'(NUM_OUT - 1));
  assign dly_addr_cur = DELAY_AW'(ch) * DELAY_AW'(NUM_OUT) + DELAY_AW'(t);

  always_comb begin
    first_mask = (state == S_IDLE) ? chan_mask : mask_q;
    first_sel  = find_from(first_mask, 0);
    after_sel  = find_from(mask_q, int'(ch) + 1);
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    next_ch    = ch;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = first_sel[CH_W] ? S_DLY_RD : S_WRITE;
          next_ch    = first_sel[CH_W-1:0];
        end
      end
      S_DLY_RD:   next_state = S_DLY_WAIT;
      S_DLY_WAIT: if (wait_last) next_state = S_SMP_RD;
      S_SMP_RD:   next_state = S_SMP_WAIT;
      S_SMP_WAIT: if (wait_last) next_state = S_ACC;
      S_ACC: begin
        if (after_sel[CH_W]) begin
          next_state = S_DLY_RD;
          next_ch    = after_sel[CH_W-1:0];
        end else begin
          next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_t) begin
          next_state = S_DONE;
        end else begin
          next_state = first_sel[CH_W] ? S_DLY_RD : S_WRITE;
          next_ch    = first_sel[CH_W-1:0];
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes come straight from the state; addresses show the live value while strobing
  // and the last strobed value otherwise.
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign delay_rd_en   = (state == S_DLY_RD);
  assign delay_rd_addr = delay_rd_en ? dly_addr_cur : dly_addr_hold;
  assign samp_rd_en    = (state == S_SMP_RD);
  assign samp_rd_addr  = samp_addr_q;
  assign sum_wr_en     = (state == S_WRITE);
  assign sum_wr_addr   = sum_wr_en ? t : wr_addr_hold;
  assign sum_wr_data   = sum_wr_en ? acc : wr_data_hold;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state         <= S_IDLE;
      ch            <= '0;
      mask_q        <= '0;
      t             <= '0;
      wait_cnt      <= '0;
      smp_q         <= '0;
      acc           <= '0;
      dly_addr_hold <= '0;
      samp_addr_q   <= '0;
      wr_addr_hold  <= '0;
      wr_data_hold  <= '0;
    end else begin
      state    <= next_state;
      ch       <= next_ch;
      wait_cnt <= ((state == S_DLY_WAIT || state == S_SMP_WAIT) && !wait_last)
                  ? wait_cnt + 1'b1 : '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q <= chan_mask;
            t      <= '0;
            acc    <= '0;
          end
        end
        S_DLY_RD:   dly_addr_hold <= dly_addr_cur;
        S_DLY_WAIT: if (wait_last) samp_addr_q <= delay_rd_data;
        S_SMP_WAIT: if (wait_last) smp_q <= samp_rd_data;
        S_ACC:      acc <= acc + SUM_W'(smp_q);
        S_WRITE: begin
          wr_addr_hold <= t;
          wr_data_hold <= acc;
          acc          <= '0;
          t            <= t + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
